bcd_sub4_serial: RTL and testbench
==================================

// Module: bcd_sub4_serial
// PURPOSE
//  Digit-serial packed-BCD subtractor, NDIG digits: computes D = A - B - BI in
//  ten's-complement BCD, least-significant digit first, one digit per clock.
//  Companion to the combinational BCD adder chain. Used wherever the design
//  decrements or compares BCD counters/scores and fewer gates are wanted than
//  a ripple chain costs. Runs a start/busy/done handshake.
// PARAMETERS
//  NDIG  4  number of BCD digits; operand width is 4*NDIG bits
// PORTS
//  clk    in   1        system clock, rising edge
//  nrst   in   1        synchronous reset, active-low
//  start  in   1        request; accepted only in IDLE
//  a      in   4*NDIG   minuend, packed BCD, digit 0 = a[3:0]
//  b      in   4*NDIG   subtrahend, packed BCD
//  bi     in   1        borrow-in into digit 0
//  busy   out  1        high in CALC and DONE
//  done   out  1        one-cycle pulse; d/bo/err valid in that cycle
//  d      out  4*NDIG   difference, packed BCD
//  bo     out  1        borrow-out of the top digit (1 = negative result, ten's comp)
//  err    out  1        an operand digit was > 9
// BEHAVIOUR
//  Reset (nrst=0 at a clk edge): state=IDLE; busy, done, bo, err = 0; d = 0;
//   internal digit counter and borrow = 0. Reset mid-operation aborts it;
//   no done pulse is produced for the aborted request.
//  States:
//   IDLE: on start=1, latch a, b and bi into shift registers; clear
//    err_acc; idx=0; go to CALC.
//   CALC: per edge, take digit idx: t = a_i - b_i - brw (signed, 5 bit).
//    If t<0: digit = t+10, brw = 1; else digit = t, brw = 0.
//    Shift the digit into the result register from the top.
//    If a_i>9 or b_i>9, set err_acc.
//    After digit NDIG-1, go to DONE.
//   DONE: one cycle, done=1, then go to IDLE. start is ignored here.
//  Timing: accept edge = k. Digits are computed on edges k+1 .. k+NDIG.
//   done is high during the cycle after edge k+NDIG. busy is high from
//   edge k until edge k+NDIG+1.
//  Outputs d, bo, err update only when entering DONE, and hold until the
//   next DONE or reset. d/bo are not changed during CALC; the working result
//   is internal.
//  err: if err_acc is set, DONE presents err=1, d=0, bo=0. Otherwise err=0.
//  Wrap: the result is modulo 10^NDIG, e.g. 0000-0001 -> 9999 with bo=1.
//  start while busy=1 is ignored and not queued. A held start re-triggers
//   in the IDLE cycle after DONE, which is the minimum spacing of NDIG+2 cycles.
//  No combinational path from the inputs to the outputs.
// TESTING
//  1 a=1234 b=0567 bi=0 -> d=0667 bo=0 err=0; done exactly 4 cycles after
//    the accept edge; busy high for 5 cycles.
//  2 a=0000 b=0001 bi=0 -> d=9999 bo=1; a=9999 b=9999 bi=1 -> d=9999 bo=1.
//  3 a=5000 b=4999 bi=1 -> d=0000 bo=0 (borrow ripples through all digits).
//  4 a=12A4 b=0001 -> err=1, d=0000, bo=0; the next valid op clears err.
//  5 pulse start again in cycles 2 and 4 of an op -> both ignored; only one
//    done; d holds until the next accept.
//  6 nrst=0 in CALC cycle 2 -> next cycle: busy=0, done=0, d=0, bo=0, err=0;
//    no done follows; a fresh start then runs normally.

Source files
------------

// File: rtl/bcd_sub4_serial.sv
// Digit-serial packed-BCD subtractor: D = A - B - BI in ten's complement,
// least-significant digit first, one digit per clock, start/busy/done handshake.
// NDIG must be at least 2.
module bcd_sub4_serial #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              bi,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] d,
    output logic              bo,
    output logic              err
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [IW-1:0] idx;
    logic          brw;
    logic          err_acc;

    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-5:0]  res;

    logic [4:0]    sub_r;
    logic [3:0]    dig;
    logic          brw_n;
    logic          err_acc_n;
    logic [W-1:0]  res_full;
    logic          last_dig;

    // One BCD digit of A - B - borrow; returns {borrow_out, digit}.
    // A negative difference is corrected by +10 and raises the borrow.
    function automatic logic [4:0] bcd_digit_sub(input logic [3:0] ad,
                                                 input logic [3:0] bd,
                                                 input logic       br);
        logic signed [5:0] t;
        logic [3:0]        dg;
        t = $signed({2'b00, ad}) - $signed({2'b00, bd}) - $signed({5'b00000, br});
        if (t < 0) begin
            dg = 4'(t + 6'sd10);
            return {1'b1, dg};
        end
        dg = 4'(t);
        return {1'b0, dg};
    endfunction

    // Current-digit arithmetic and the result word as it looks after this digit.
    always_comb begin
        sub_r     = bcd_digit_sub(a_sh[3:0], b_sh[3:0], brw);
        dig       = sub_r[3:0];
        brw_n     = sub_r[4];
        err_acc_n = err_acc | (a_sh[3:0] > 4'd9) | (b_sh[3:0] > 4'd9);
        res_full  = {dig, res};
        last_dig  = (idx == IW'(NDIG - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic; busy/done decode straight from the state register.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (last_dig) state_n = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Control state and visible results; results change only on the edge into DONE.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            idx     <= '0;
            brw     <= 1'b0;
            err_acc <= 1'b0;
            d       <= '0;
            bo      <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        brw     <= bi;
                        err_acc <= 1'b0;
                    end
                end
                S_CALC: begin
                    idx     <= idx + 1'b1;
                    brw     <= brw_n;
                    err_acc <= err_acc_n;
                    if (last_dig) begin
                        err <= err_acc_n;
                        d   <= err_acc_n ? '0 : res_full;
                        bo  <= err_acc_n ? 1'b0 : brw_n;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand shift registers and working result; digits enter the result from the top.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            a_sh <= a;
            b_sh <= b;
        end else if (state == S_CALC) begin
            a_sh <= a_sh >> 4;
            b_sh <= b_sh >> 4;
            res  <= res_full[W-1:4];
        end
    end

endmodule

// File: tb/tb_bcd_sub4_serial.sv
// Self-checking bench for bcd_sub4_serial: vector table, handshake corner
// cases and randomized operations against an integer-arithmetic model.
module tb_bcd_sub4_serial;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk   = 1'b0;
    logic         nrst  = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bi    = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_sub4_serial #(.NDIG(NDIG)) dut (
        .clk  (clk),
        .nrst (nrst),
        .start(start),
        .a    (a),
        .b    (b),
        .bi   (bi),
        .busy (busy),
        .done (done),
        .d    (d),
        .bo   (bo),
        .err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] d;
        logic         bo;
        logic         err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: decode BCD to integers, subtract, wrap modulo 10^NDIG, re-encode.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic biv,
                         output logic [W-1:0] md, output logic mbo, output logic merr);
        int x, y, diff, p, mod;
        x = 0; y = 0; p = 1; merr = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (av[4*i +: 4] > 9 || bv[4*i +: 4] > 9) merr = 1'b1;
            x += int'(av[4*i +: 4]) * p;
            y += int'(bv[4*i +: 4]) * p;
            p *= 10;
        end
        mod  = p;
        diff = x - y - int'(biv);
        mbo  = 1'b0;
        if (diff < 0) begin
            diff += mod;
            mbo = 1'b1;
        end
        md = '0;
        for (int i = 0; i < NDIG; i++) begin
            md[4*i +: 4] = 4'(diff % 10);
            diff /= 10;
        end
        if (merr) begin
            md  = '0;
            mbo = 1'b0;
        end
    endtask

    // One full operation; checks done latency, single pulse and busy length.
    // With poke set, start is re-pulsed twice while the operation is busy.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic biv, input bit poke,
                          output logic [W-1:0] rd, output logic rbo, output logic rerr);
        int e, de, dc, bc;
        rd = '0; rbo = 1'b0; rerr = 1'b0;
        @(negedge clk);
        a = av; b = bv; bi = biv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bc = busy ? 1 : 0;
        de = -1; dc = 0; e = 0;
        while (e < 30) begin
            @(posedge clk);
            #1;
            e++;
            if (busy) bc++;
            if (done) begin
                dc++;
                if (de < 0) de = e;
                rd = d; rbo = bo; rerr = err;
            end
            start = poke && (e == 1 || e == 3);
            if (!busy && e > NDIG) break;
        end
        start = 1'b0;
        chk({tag, " done latency"}, de, NDIG);
        chk({tag, " done pulses"}, dc, 1);
        chk({tag, " busy cycles"}, bc, NDIG + 1);
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic biv, input bit poke);
        logic [W-1:0] rd, md;
        logic rbo, rerr, mbo, merr;
        run_op(tag, av, bv, biv, poke, rd, rbo, rerr);
        model(av, bv, biv, md, mbo, merr);
        chk({tag, " d"}, rd, md);
        chk({tag, " bo"}, rbo, mbo);
        chk({tag, " err"}, rerr, merr);
    endtask

    initial begin
        logic [W-1:0] rd, ra, rb;
        logic rbo, rerr;
        int dcnt, e1, gap;

        vecs[0] = '{a:16'h1234, b:16'h0567, bi:1'b0, d:16'h0667, bo:1'b0, err:1'b0};
        vecs[1] = '{a:16'h0000, b:16'h0001, bi:1'b0, d:16'h9999, bo:1'b1, err:1'b0};
        vecs[2] = '{a:16'h9999, b:16'h9999, bi:1'b1, d:16'h9999, bo:1'b1, err:1'b0};
        vecs[3] = '{a:16'h5000, b:16'h4999, bi:1'b1, d:16'h0000, bo:1'b0, err:1'b0};
        vecs[4] = '{a:16'h12A4, b:16'h0001, bi:1'b0, d:16'h0000, bo:1'b0, err:1'b1};
        vecs[5] = '{a:16'h9999, b:16'h0000, bi:1'b0, d:16'h9999, bo:1'b0, err:1'b0};
        vecs[6] = '{a:16'h0000, b:16'h0000, bi:1'b1, d:16'h9999, bo:1'b1, err:1'b0};
        vecs[7] = '{a:16'h4321, b:16'h1234, bi:1'b0, d:16'h3087, bo:1'b0, err:1'b0};

        // Reset state
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset d", d, 0);
        chk("reset bo", bo, 0);
        chk("reset err", err, 0);
        nrst = 1'b1;

        // Vector table; vector 5 follows the error case and must clear err
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi, 1'b0, rd, rbo, rerr);
            chk($sformatf("vec%0d d", i), rd, vecs[i].d);
            chk($sformatf("vec%0d bo", i), rbo, vecs[i].bo);
            chk($sformatf("vec%0d err", i), rerr, vecs[i].err);
        end

        // start pulses while busy are ignored; d holds afterwards
        run_op("poke", 16'h1234, 16'h0567, 1'b0, 1'b1, rd, rbo, rerr);
        chk("poke d", rd, 16'h0667);
        dcnt = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            chk("poke hold d", d, 16'h0667);
        end
        chk("poke no extra done", dcnt, 0);

        // Held start re-triggers at the minimum spacing of NDIG+2 cycles
        @(negedge clk);
        a = 16'h0042; b = 16'h0017; bi = 1'b0; start = 1'b1;
        e1 = -1; gap = -1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (e1 < 0) e1 = e;
                else if (gap < 0) gap = e - e1;
            end
        end
        start = 1'b0;
        chk("held start spacing", gap, NDIG + 2);
        chk("held start d", d, 16'h0025);
        repeat (NDIG + 3) @(posedge clk);

        // Reset during CALC aborts the operation
        run_op("pre-rst", 16'h1234, 16'h0567, 1'b0, 1'b0, rd, rbo, rerr);
        @(negedge clk);
        a = 16'h0000; b = 16'h0001; bi = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 nrst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort d", d, 0);
        chk("abort bo", bo, 0);
        chk("abort err", err, 0);
        nrst = 1'b1;
        dcnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        chk("abort no done", dcnt, 0);
        op_check("post-rst", 16'h5000, 16'h4999, 1'b1, 1'b0);

        // Randomized operations, occasionally with invalid digits
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NDIG; i++) begin
                ra[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
                rb[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            end
            op_check($sformatf("rnd%0d", n), ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
